aes_round_seq: RTL and testbench

AES_ROUND_SEQ -- requirements
Module: aes_round_seq

---
 rtl/aes_round_seq.sv | 152 +++++++++++++++
 tb/tb_aes_round_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_seq.sv
// aes_round_seq: round sequencer for an iterative AES datapath.
// One block is NUM_ROUNDS rounds of SBOX_LATENCY cycles each. The block
// produces key-schedule control (key_load, key_reg_en, rcon), a round index,
// a final-round flag and a one-cycle done pulse.
module aes_round_seq #(
    parameter int          SBOX_LATENCY  = 5,
    parameter int          NUM_ROUNDS    = 10,
    parameter logic [7:0]  RCON_DEC_INIT = 8'h36
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dec,
    input  logic       abort,
    output logic       busy,
    output logic       key_load,
    output logic       key_reg_en,
    output logic [7:0] rcon,
    output logic [3:0] round_idx,
    output logic       final_round,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_PHASE = 4'(SBOX_LATENCY - 1);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
    localparam logic [7:0] RCON_ENC_INIT = 8'h01;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] phase_q;
    logic [3:0] round_q;
    logic [7:0] rcon_q;
    logic       dec_q;

    logic       accept;       // start taken this cycle
    logic       wrap;         // last cycle of the current round
    logic       more_rounds;  // current round is not the last one

    // Forward round-constant step: multiply by x in GF(2^8).
    function automatic logic [7:0] rcon_fwd(input logic [7:0] b);
        rcon_fwd = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Inverse of rcon_fwd: divide by x in GF(2^8).
    function automatic logic [7:0] rcon_inv(input logic [7:0] b);
        logic [7:0] t;
        t = b ^ 8'h1B;
        rcon_inv = b[0] ? {1'b1, t[7:1]} : {1'b0, b[7:1]};
    endfunction

    // abort outranks start even in IDLE, so a simultaneous pair is a no-op.
    assign accept      = (state_q == IDLE) && start && !abort;
    assign wrap        = (state_q == RUN) && (phase_q == LAST_PHASE);
    assign more_rounds = (round_q < LAST_ROUND);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (wrap && !more_rounds) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode; round_idx reads 0 in IDLE while round_q keeps its value.
    always_comb begin
        busy        = (state_q == RUN);
        done        = (state_q == DONE);
        key_load    = accept;
        key_reg_en  = accept || (wrap && more_rounds);
        final_round = (state_q == RUN) && (round_q == LAST_ROUND);
        rcon        = rcon_q;
        round_idx   = (state_q == IDLE) ? 4'd0 : round_q;
    end

    // Phase counter: runs only in RUN, restarts at 0 for every round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 4'd0;
        end else if (accept) begin
            phase_q <= 4'd0;
        end else if (state_q == RUN) begin
            phase_q <= wrap ? 4'd0 : phase_q + 4'd1;
        end else begin
            phase_q <= 4'd0;
        end
    end

    // Mode latch: dec only matters at the accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q <= 1'b0;
        end else if (accept) begin
            dec_q <= dec;
        end
    end

    // Round index and round constant: advance at each non-final round wrap,
    // otherwise hold (including through IDLE after done or abort).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_q <= 4'd0;
            rcon_q  <= 8'h00;
        end else if (accept) begin
            round_q <= 4'd1;
            rcon_q  <= dec ? RCON_DEC_INIT : RCON_ENC_INIT;
        end else if (wrap && more_rounds && !abort) begin
            round_q <= round_q + 4'd1;
            rcon_q  <= dec_q ? rcon_inv(rcon_q) : rcon_fwd(rcon_q);
        end
    end

    // Completion, key load and final round are mutually exclusive by state.
    a_excl : assert property (@(posedge clk) disable iff (!rst_n)
        !(done && key_load) && !(done && final_round) && !(key_load && final_round));

    // DONE never lasts more than one cycle.
    a_done_pulse : assert property (@(posedge clk) disable iff (!rst_n)
        done |=> !done);

endmodule

// File: tb/tb_aes_round_seq.sv
// Bench for aes_round_seq: table of block vectors plus hand sequences for
// abort, reset, back-to-back start and a 2-cycle/14-round configuration.
module tb_aes_round_seq;

    localparam int L = 5;
    localparam int N = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       dec = 1'b0;
    logic       abort = 1'b0;
    logic       busy, key_load, key_reg_en, final_round, done;
    logic [7:0] rcon;
    logic [3:0] round_idx;

    logic       start2 = 1'b0;
    logic       busy2, kl2, kre2, fr2, done2;
    logic [7:0] rcon2;
    logic [3:0] ri2;

    aes_round_seq #(.SBOX_LATENCY(L), .NUM_ROUNDS(N), .RCON_DEC_INIT(8'h36)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dec(dec), .abort(abort),
        .busy(busy), .key_load(key_load), .key_reg_en(key_reg_en), .rcon(rcon),
        .round_idx(round_idx), .final_round(final_round), .done(done)
    );

    aes_round_seq #(.SBOX_LATENCY(2), .NUM_ROUNDS(14), .RCON_DEC_INIT(8'h36)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .dec(1'b0), .abort(1'b0),
        .busy(busy2), .key_load(kl2), .key_reg_en(kre2), .rcon(rcon2),
        .round_idx(ri2), .final_round(fr2), .done(done2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: one entry per round start plus one for the done pulse.
    typedef struct {
        bit         is_done;
        int         at;
        logic [3:0] round;
        logic [7:0] rc;
    } exp_t;
    exp_t exp_q[$];
    int   blk_start = -1000;

    task automatic push_block(input int s, input logic [9:0][7:0] rc);
        exp_t e;
        for (int r = 1; r <= N; r++) begin
            e.is_done = 1'b0;
            e.at      = s + 1 + (r - 1) * L;
            e.round   = 4'(r);
            e.rc      = rc[r-1];
            exp_q.push_back(e);
        end
        e.is_done = 1'b1;
        e.at      = s + N * L + 1;
        e.round   = 4'd0;
        e.rc      = 8'h00;
        exp_q.push_back(e);
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard at each round
    // start and at done, and checks per-cycle invariants.
    logic       prev_busy = 1'b0;
    logic [3:0] prev_round = 4'd0;
    always @(negedge clk) begin
        exp_t e;
        int   k;
        if (rst_n) begin
            if (busy && (!prev_busy || round_idx != prev_round)) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_round: got round %0d with empty scoreboard", round_idx);
                end else begin
                    e = exp_q.pop_front();
                    chk("slot_kind_round", 32'(e.is_done), 32'd0);
                    chk("round_idx", 32'(round_idx), 32'(e.round));
                    chk("rcon", 32'(rcon), 32'(e.rc));
                    chk("round_start_cycle", cyc, e.at);
                end
            end
            if (busy) begin
                k = cyc - blk_start;
                chk("final_round", 32'(final_round), 32'(round_idx == 4'(N)));
                chk("key_reg_en_run", 32'(key_reg_en), 32'((k % L == 0) && (k < N * L)));
                chk("key_load_in_run", 32'(key_load), 32'd0);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got done=1 with empty scoreboard");
                end else begin
                    e = exp_q.pop_front();
                    chk("slot_kind_done", 32'(e.is_done), 32'd1);
                    chk("done_cycle", cyc, e.at);
                end
                chk("done_excl", 32'({key_load, final_round, busy}), 32'd0);
            end
            if (!busy && !done) begin
                chk("idle_round_idx", 32'(round_idx), 32'd0);
            end
        end
        prev_busy  <= busy;
        prev_round <= round_idx;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    // Wait for done (bounded), then let the monitor see it and confirm the
    // scoreboard drained.
    task automatic wait_done(input int limit);
        int w;
        w = 0;
        while (!done && w < limit) begin
            tick();
            w++;
        end
        chk("done_seen", 32'(done), 32'd1);
        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Accept a block now; dec is flipped right after to prove it is latched.
    task automatic run_block(input bit d, input logic [9:0][7:0] rc);
        int s;
        start = 1'b1;
        dec   = d;
        #1;
        chk("key_load_accept", 32'(key_load), 32'd1);
        chk("key_reg_en_accept", 32'(key_reg_en), 32'd1);
        s = cyc;
        blk_start = s;
        push_block(s, rc);
        tick();
        start = 1'b0;
        dec   = ~d;
        wait_done(200);
        chk("rcon_hold_idle", 32'(rcon), 32'(rc[N-1]));
    endtask

    typedef struct {
        bit               d;
        logic [9:0][7:0]  rc;
    } vec_t;

    initial begin
        vec_t             vecs[3];
        logic [9:0][7:0]  enc_rc;
        logic [9:0][7:0]  dec_rc;
        int               s;
        int               k;

        enc_rc = {8'h36, 8'h1B, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        dec_rc = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
        vecs[0].d = 1'b0; vecs[0].rc = enc_rc;
        vecs[1].d = 1'b1; vecs[1].rc = dec_rc;
        vecs[2].d = 1'b0; vecs[2].rc = enc_rc;

        // Reset state.
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rcon", 32'(rcon), 32'd0);
        chk("rst_round_idx", 32'(round_idx), 32'd0);
        chk("rst_outs", 32'({key_load, key_reg_en, final_round, done}), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();

        // Table-driven blocks.
        for (int i = 0; i < 3; i++) begin
            run_block(vecs[i].d, vecs[i].rc);
            tick();
        end

        // Start held high: pulses during RUN are ignored, the next block is
        // accepted the cycle after done.
        start = 1'b1;
        dec   = 1'b0;
        #1;
        s = cyc;
        blk_start = s;
        push_block(s, enc_rc);
        push_block(s + N * L + 2, enc_rc);
        wait_until(s + N * L + 2);
        blk_start = s + N * L + 2;
        chk("held_start_reaccept", 32'(key_load), 32'd1);
        tick();
        start = 1'b0;
        wait_done(200);
        tick();

        // Abort at cycle 12 of a block.
        start = 1'b1;
        #1;
        s = cyc;
        blk_start = s;
        push_block(s, enc_rc);
        tick();
        start = 1'b0;
        wait_until(s + 12);
        abort = 1'b1;
        exp_q.delete();
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_round_idx", 32'(round_idx), 32'd0);
        for (int j = 0; j < 60; j++) begin
            chk("abort_no_done", 32'(done), 32'd0);
            tick();
        end
        // start and abort together in IDLE are ignored.
        start = 1'b1;
        abort = 1'b1;
        #1;
        chk("start_abort_key_load", 32'(key_load), 32'd0);
        tick();
        chk("start_abort_idle", 32'(busy), 32'd0);
        start = 1'b0;
        abort = 1'b0;
        tick();

        // Reset mid-block at cycle 30.
        start = 1'b1;
        #1;
        s = cyc;
        blk_start = s;
        push_block(s, enc_rc);
        tick();
        start = 1'b0;
        wait_until(s + 30);
        #1;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rcon", 32'(rcon), 32'd0);
        chk("midrst_round_idx", 32'(round_idx), 32'd0);
        chk("midrst_outs", 32'({key_load, key_reg_en, final_round, done}), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        for (int j = 0; j < 60; j++) begin
            chk("midrst_no_done", 32'(done), 32'd0);
            tick();
        end
        run_block(1'b0, enc_rc);
        tick();

        // SBOX_LATENCY=2, NUM_ROUNDS=14.
        start2 = 1'b1;
        #1;
        chk("cfg2_key_load", 32'(kl2), 32'd1);
        s = cyc;
        tick();
        start2 = 1'b0;
        for (int j = 0; j < 34; j++) begin
            k = cyc - s;
            if (k >= 1 && k <= 28) begin
                chk("cfg2_round_idx", 32'(ri2), 32'((k - 1) / 2 + 1));
                chk("cfg2_busy", 32'(busy2), 32'd1);
                chk("cfg2_final", 32'(fr2), 32'(k >= 27));
                chk("cfg2_key_reg_en", 32'(kre2), 32'((k % 2 == 0) && (k < 28)));
            end
            chk("cfg2_done", 32'(done2), 32'(k == 29));
            tick();
        end
        chk("cfg2_rcon_last", 32'(rcon2), 32'h4D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
